// File: rtl/svm_sched_ctrl_pkg.sv
// rtl/svm_sched_ctrl_pkg.sv - shared types, widths and defaults for the SVM scheduler
package svm_sched_ctrl_pkg;

    localparam int FEAT_W          = 32;
    localparam int TIMEOUT_CYC_DEF = 64;
    localparam int CONFIRM_N_DEF   = 2;
    localparam int CONF_W          = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } sched_state_e;

    // Saturating increment for the confirm counter: sticks at all-ones.
    function automatic logic [CONF_W-1:0] sat_inc(input logic [CONF_W-1:0] v);
        return (v == {CONF_W{1'b1}}) ? v : v + CONF_W'(1);
    endfunction

endpackage

// File: rtl/svm_sched_ctrl_if.sv
// rtl/svm_sched_ctrl_if.sv - feature stream and SVM datapath bundles
interface svm_feat_if;
    import svm_sched_ctrl_pkg::*;

    logic              feat_valid;
    logic              feat_ready;
    logic [FEAT_W-1:0] feat_mean;
    logic [FEAT_W-1:0] feat_std;

    modport master (output feat_valid, output feat_mean, output feat_std, input feat_ready);
    modport slave  (input feat_valid, input feat_mean, input feat_std, output feat_ready);
endinterface

interface svm_dp_if;
    import svm_sched_ctrl_pkg::*;

    logic              svm_start;
    logic [FEAT_W-1:0] svm_mean;
    logic [FEAT_W-1:0] svm_std;
    logic              svm_done;
    logic              svm_fall;

    modport master (output svm_start, output svm_mean, output svm_std,
                    input svm_done, input svm_fall);
    modport slave  (input svm_start, input svm_mean, input svm_std,
                    output svm_done, output svm_fall);
endinterface

// File: rtl/svm_sched_ctrl_fall_confirm.sv
// rtl/svm_sched_ctrl_fall_confirm.sv - consecutive-fall confirm counter and sticky alarm
module fall_confirm
    import svm_sched_ctrl_pkg::*;
#(
    parameter int CONFIRM_N = CONFIRM_N_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic result_valid,
    input  logic result_fall,
    input  logic timeout,
    input  logic alarm_clear,
    output logic fall_alarm
);

    logic [CONF_W-1:0] cnt_q, cnt_d;
    logic              alarm_q, alarm_d;
    logic [CONF_W-1:0] cnt_inc;

    // Counter and alarm registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
        end
    end

    // Clear dominates; otherwise a fall result extends the streak and may arm the alarm.
    always_comb begin
        cnt_d   = cnt_q;
        alarm_d = alarm_q;
        cnt_inc = sat_inc(cnt_q);
        if (alarm_clear) begin
            cnt_d   = '0;
            alarm_d = 1'b0;
        end else if (timeout) begin
            cnt_d = '0;
        end else if (result_valid) begin
            if (result_fall) begin
                cnt_d = cnt_inc;
                if (cnt_inc == CONF_W'(CONFIRM_N)) begin
                    alarm_d = 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    assign fall_alarm = alarm_q;

endmodule

// File: rtl/svm_sched_ctrl.sv
// rtl/svm_sched_ctrl.sv - single-job scheduler for the SVM fall-detection datapath
module svm_sched_ctrl
    import svm_sched_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CONFIRM_N   = CONFIRM_N_DEF
) (
    input  logic       clk,
    input  logic       reset,
    svm_feat_if.slave  feat,
    svm_dp_if.master   dp,
    output logic       result_valid,
    output logic       result_fall,
    output logic       fall_alarm,
    input  logic       alarm_clear,
    output logic       timeout_err
);

    localparam int            TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    sched_state_e      state_q, state_d;
    logic [FEAT_W-1:0] mean_q, mean_d;
    logic [FEAT_W-1:0] std_q, std_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              fall_q, fall_d;

    // State and job registers; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mean_q  <= '0;
            std_q   <= '0;
            tmo_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mean_q  <= mean_d;
            std_q   <= std_d;
            tmo_q   <= tmo_d;
            fall_q  <= fall_d;
        end
    end

    // Next state: done wins over an expiring counter in the last WAIT cycle.
    always_comb begin
        state_d = state_q;
        mean_d  = mean_q;
        std_d   = std_q;
        tmo_d   = tmo_q;
        fall_d  = fall_q;
        case (state_q)
            IDLE: begin
                if (feat.feat_valid) begin
                    mean_d  = feat.feat_mean;
                    std_d   = feat.feat_std;
                    state_d = START;
                end
            end
            START: begin
                tmo_d   = TMO_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (dp.svm_done) begin
                    fall_d  = dp.svm_fall;
                    state_d = REPORT;
                end else if (tmo_q == '0) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state; ready is held low while in reset.
    always_comb begin
        feat.feat_ready = (state_q == IDLE) && !reset;
        dp.svm_start    = (state_q == START);
        result_valid    = (state_q == REPORT);
        timeout_err     = (state_q == WAIT) && !dp.svm_done && (tmo_q == '0);
    end

    assign dp.svm_mean  = mean_q;
    assign dp.svm_std   = std_q;
    assign result_fall  = fall_q;

    fall_confirm #(
        .CONFIRM_N (CONFIRM_N)
    ) u_confirm (
        .clk          (clk),
        .reset        (reset),
        .result_valid (result_valid),
        .result_fall  (result_fall),
        .timeout      (timeout_err),
        .alarm_clear  (alarm_clear),
        .fall_alarm   (fall_alarm)
    );

endmodule
